column_plotter: RTL and testbench

COLUMN_PLOTTER -- requirements
Module: column_plotter

---
 rtl/column_plotter_if.sv | 26 ++
 rtl/column_plotter.sv | 146 ++++++++++++++
 tb/tb_column_plotter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/column_plotter_if.sv
// Pixel-column request/result bundle between a column requester and the plotter.
interface column_plotter_if;
   logic       start_plot;
   logic [7:0] X_pos_in;
   logic [6:0] Y_pos_in;
   logic [6:0] rect_size;
   logic [2:0] color_in;
   logic [2:0] ceil_color;
   logic [2:0] floor_color;
   logic       plot_enable;
   logic [7:0] X;
   logic [6:0] Y;
   logic [2:0] color_out;
   logic       busy;
   logic       end_plot;

   modport master (
      output start_plot, X_pos_in, Y_pos_in, rect_size, color_in, ceil_color, floor_color,
      input  plot_enable, X, Y, color_out, busy, end_plot
   );

   modport slave (
      input  start_plot, X_pos_in, Y_pos_in, rect_size, color_in, ceil_color, floor_color,
      output plot_enable, X, Y, color_out, busy, end_plot
   );
endinterface

// File: rtl/column_plotter.sv
// Paints one screen column top to bottom (ceiling, wall, floor), one registered pixel per cycle.
// First pixel appears the cycle after start is accepted; start is ignored while busy.
module column_plotter #(
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120
) (
   input  logic            clock,
   input  logic            reset,
   column_plotter_if.slave bus
);
   localparam logic [7:0] W8       = 8'(SCREEN_W);
   localparam logic [7:0] H8       = 8'(SCREEN_H);
   localparam logic [6:0] LAST_ROW = 7'(SCREEN_H - 1);

   typedef enum logic [1:0] {S_IDLE, S_PLOT, S_DONE} state_t;

   state_t     state_q, state_d;
   logic [6:0] row_q, row_d;
   logic [7:0] xl_q, xl_d;
   logic [6:0] top_q, top_d;
   logic [6:0] size_q, size_d;
   logic [2:0] wall_q, wall_d;
   logic [2:0] ceil_q, ceil_d;
   logic [2:0] floor_q, floor_d;
   logic       pe_q, pe_d;
   logic [7:0] x_q, x_d;
   logic [6:0] y_q, y_d;
   logic [2:0] col_q, col_d;
   logic       busy_q, busy_d;
   logic       end_q, end_d;
   logic [6:0] row_nxt;

   // Wall end is formed 8 bits wide so top+size never wraps before clamping.
   function automatic logic [2:0] row_color(input logic [6:0] row, input logic [6:0] top,
                                            input logic [6:0] size, input logic [2:0] wall,
                                            input logic [2:0] ceil, input logic [2:0] flr);
      logic [7:0] wall_end;
      wall_end = {1'b0, top} + {1'b0, size};
      if (wall_end > H8) wall_end = H8;
      if (row < top) return ceil;
      if ({1'b0, row} < wall_end) return wall;
      return flr;
   endfunction

   assign row_nxt = row_q + 7'd1;

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      xl_d    = xl_q;
      top_d   = top_q;
      size_d  = size_q;
      wall_d  = wall_q;
      ceil_d  = ceil_q;
      floor_d = floor_q;
      pe_d    = 1'b0;
      x_d     = 8'd0;
      y_d     = 7'd0;
      col_d   = 3'd0;
      busy_d  = 1'b0;
      end_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start_plot) begin
               xl_d    = bus.X_pos_in;
               top_d   = bus.Y_pos_in;
               size_d  = bus.rect_size;
               wall_d  = bus.color_in;
               ceil_d  = bus.ceil_color;
               floor_d = bus.floor_color;
               row_d   = 7'd0;
               busy_d  = 1'b1;
               if (bus.X_pos_in >= W8) begin
                  state_d = S_DONE;
                  end_d   = 1'b1;
               end else begin
                  state_d = S_PLOT;
                  pe_d    = 1'b1;
                  x_d     = bus.X_pos_in;
                  col_d   = row_color(7'd0, bus.Y_pos_in, bus.rect_size, bus.color_in,
                                      bus.ceil_color, bus.floor_color);
               end
            end
         end
         S_PLOT: begin
            busy_d = 1'b1;
            if (row_q == LAST_ROW) begin
               state_d = S_DONE;
               end_d   = 1'b1;
            end else begin
               row_d = row_nxt;
               pe_d  = 1'b1;
               x_d   = xl_q;
               y_d   = row_nxt;
               col_d = row_color(row_nxt, top_q, size_q, wall_q, ceil_q, floor_q);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            row_d   = 7'd0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         row_q   <= 7'd0;
         xl_q    <= 8'd0;
         top_q   <= 7'd0;
         size_q  <= 7'd0;
         wall_q  <= 3'd0;
         ceil_q  <= 3'd0;
         floor_q <= 3'd0;
         pe_q    <= 1'b0;
         x_q     <= 8'd0;
         y_q     <= 7'd0;
         col_q   <= 3'd0;
         busy_q  <= 1'b0;
         end_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         xl_q    <= xl_d;
         top_q   <= top_d;
         size_q  <= size_d;
         wall_q  <= wall_d;
         ceil_q  <= ceil_d;
         floor_q <= floor_d;
         pe_q    <= pe_d;
         x_q     <= x_d;
         y_q     <= y_d;
         col_q   <= col_d;
         busy_q  <= busy_d;
         end_q   <= end_d;
      end
   end

   assign bus.plot_enable = pe_q;
   assign bus.X           = x_q;
   assign bus.Y           = y_q;
   assign bus.color_out   = col_q;
   assign bus.busy        = busy_q;
   assign bus.end_plot    = end_q;
endmodule

// File: tb/tb_column_plotter.sv
// Directed bench for column_plotter: checks every pixel, end_plot timing, busy and reset behaviour.
module tb_column_plotter;
   localparam int W   = 160;
   localparam int H   = 120;
   localparam int PER = H + 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   // per-column stimulus plus hand-derived row where ceiling ends (ce) and wall ends (we)
   int sx[3], sy[3], ss[3], sw[3], sc[3], sf[3], ece[3], ewe[3];

   column_plotter_if bus();

   column_plotter #(.SCREEN_W(W), .SCREEN_H(H)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus.slave)
   );

   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic set_col(input int j, input int x, input int y, input int s, input int w,
                          input int c, input int f, input int ce, input int we);
      sx[j] = x; sy[j] = y; ss[j] = s; sw[j] = w; sc[j] = c; sf[j] = f; ece[j] = ce; ewe[j] = we;
   endtask

   task automatic drive(input int j);
      bus.X_pos_in    = 8'(sx[j]);
      bus.Y_pos_in    = 7'(sy[j]);
      bus.rect_size   = 7'(ss[j]);
      bus.color_in    = 3'(sw[j]);
      bus.ceil_color  = 3'(sc[j]);
      bus.floor_color = 3'(sf[j]);
   endtask

   task automatic scramble();
      bus.X_pos_in    = 8'($urandom_range(0, 159));
      bus.Y_pos_in    = 7'($urandom);
      bus.rect_size   = 7'($urandom);
      bus.color_in    = 3'($urandom);
      bus.ceil_color  = 3'($urandom);
      bus.floor_color = 3'($urandom);
   endtask

   // Start held high; next column's inputs appear mid-column so only acceptance-time values count.
   task automatic run(input string tag, input int ncols);
      int nbad = 0, nwr = 0, nend = 0, nbusy = 0, j, p;
      logic [2:0] ec;
      logic exp_end;
      @(negedge clk);
      drive(0);
      bus.start_plot = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= PER * ncols + 3; c++) begin
         @(negedge clk);
         j = (c - 1) / PER;
         p = (c - 1) % PER;
         if (bus.plot_enable === 1'b1) nwr++;
         if (bus.end_plot === 1'b1) nend++;
         if (bus.busy === 1'b1) nbusy++;
         if (j < ncols && p < H) begin
            ec = 3'((p < ece[j]) ? sc[j] : (p < ewe[j]) ? sw[j] : sf[j]);
            if (bus.plot_enable !== 1'b1 || bus.X !== 8'(sx[j]) || bus.Y !== 7'(p) ||
                bus.color_out !== ec || bus.end_plot !== 1'b0 || bus.busy !== 1'b1) nbad++;
         end else begin
            exp_end = (j < ncols && p == H);
            if (bus.plot_enable !== 1'b0 || bus.X !== 8'd0 || bus.Y !== 7'd0 ||
                bus.color_out !== 3'd0 || bus.end_plot !== exp_end || bus.busy !== exp_end) nbad++;
         end
         if (j < ncols && p == 60) begin
            if (j + 1 < ncols) drive(j + 1);
            else begin
               bus.start_plot = 1'b0;
               scramble();
            end
         end
      end
      check({tag, " pixel/timing errors"}, nbad, 0);
      check({tag, " writes"}, nwr, H * ncols);
      check({tag, " end_plot pulses"}, nend, ncols);
      check({tag, " busy cycles"}, nbusy, (H + 1) * ncols);
   endtask

   task automatic out_of_range(input string tag, input int x);
      int nwr = 0, nend = 0, nbusy = 0, endc = -1;
      @(negedge clk);
      bus.X_pos_in   = 8'(x);
      bus.start_plot = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         if (bus.plot_enable === 1'b1) nwr++;
         if (bus.busy === 1'b1) nbusy++;
         if (bus.end_plot === 1'b1) begin
            nend++;
            if (endc < 0) endc = c;
         end
         if (c == 1) bus.start_plot = 1'b0;
      end
      check({tag, " writes"}, nwr, 0);
      check({tag, " end_plot pulses"}, nend, 1);
      check({tag, " end_plot cycle"}, endc, 1);
      check({tag, " busy cycles"}, nbusy, 1);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, " plot_enable"}, bus.plot_enable, 0);
      check({tag, " X"}, bus.X, 0);
      check({tag, " Y"}, bus.Y, 0);
      check({tag, " color_out"}, bus.color_out, 0);
      check({tag, " busy"}, bus.busy, 0);
      check({tag, " end_plot"}, bus.end_plot, 0);
   endtask

   initial begin
      int nwr, nend;
      set_col(0, 5, 40, 40, 4, 1, 2, 40, 80);
      drive(0);
      bus.start_plot = 1'b1;   // reset must win over a concurrent start
      repeat (3) @(negedge clk);
      check_quiet("reset");
      bus.start_plot = 1'b0;
      rst = 1'b0;

      set_col(0, 5, 40, 40, 4, 1, 2, 40, 80);
      run("basic", 1);
      set_col(0, 159, 100, 60, 5, 3, 6, 100, 120);
      run("clamp", 1);
      set_col(0, 0, 60, 0, 7, 1, 2, 60, 60);
      run("zero size", 1);
      set_col(0, 77, 127, 127, 7, 4, 2, 120, 120);
      run("top off screen", 1);

      set_col(0, 10, 0, 120, 3, 5, 6, 0, 120);
      set_col(1, 20, 119, 1, 1, 2, 4, 119, 120);
      set_col(2, 30, 20, 30, 6, 0, 7, 20, 50);
      run("back-to-back", 3);

      out_of_range("x=160", 160);
      out_of_range("x=255", 255);

      // abandon a column at row 50
      set_col(0, 5, 40, 40, 4, 1, 2, 40, 80);
      @(negedge clk);
      drive(0);
      bus.start_plot = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 51; c++) begin
         @(negedge clk);
         if (c == 1) bus.start_plot = 1'b0;
      end
      check("mid-reset row before reset", bus.Y, 50);
      rst = 1'b1;
      @(negedge clk);
      check_quiet("mid-reset");
      rst = 1'b0;
      nwr = 0;
      nend = 0;
      repeat (130) begin
         @(negedge clk);
         if (bus.plot_enable === 1'b1) nwr++;
         if (bus.end_plot === 1'b1) nend++;
      end
      check("mid-reset stray writes", nwr, 0);
      check("mid-reset stray end_plot", nend, 0);
      run("after reset", 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
